// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default geometry and the queued
// prediction record used by the branch update queue.
package bp_pkg;

    localparam int BP_PC_W  = 10;
    localparam int BP_PH_W  = 12;
    localparam int BP_DEPTH = 8;

    // Overriding PC_W/PH_W on the queue requires these widths to follow.
    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic [BP_PH_W-1:0] ph;
        logic               lp;
        logic               gp;
        logic               pred;
    } bq_entry_t;

endpackage

// File: rtl/branch_update_queue.sv
// In-order queue of in-flight branch predictions; retires the oldest entry on
// resolution and emits a registered training/recovery record one cycle later.
module branch_update_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int PC_W  = BP_PC_W,
    parameter int PH_W  = BP_PH_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [PC_W-1:0]         PC,
    input  logic [PH_W-1:0]         PHresult,
    input  logic                    LPresult,
    input  logic                    GPresult,
    input  logic                    PredictedBranch,
    input  logic                    resolve_valid,
    input  logic                    BranchTaken,
    output logic                    upd_valid,
    output logic                    upd_taken,
    output logic                    lp_correct,
    output logic                    gp_correct,
    output logic                    cp_train,
    output logic                    cp_dir,
    output logic                    mispredict,
    output logic [PC_W-1:0]         upd_PC,
    output logic [PH_W-1:0]         upd_PH,
    output logic [PH_W-1:0]         recover_PH,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    underflow_err
);

    localparam int AW = $clog2(DEPTH);

    bq_entry_t      mem [DEPTH];
    bq_entry_t      head_e;
    bq_entry_t      wr_e;
    logic [AW:0]    head;
    logic [AW:0]    tail;
    logic           full;
    logic           alloc_fire;
    logic           retire_fire;
    logic           retire_mis;

    // Same slot index with differing wrap bits means the tail lapped the head.
    assign full        = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
    assign alloc_ready = !full;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign retire_fire = resolve_valid && (count != '0);
    assign head_e      = mem[head[AW-1:0]];
    assign retire_mis  = retire_fire && (head_e.pred != BranchTaken);

    always_comb begin
        wr_e      = '0;
        wr_e.pc   = PC;
        wr_e.ph   = PHresult;
        wr_e.lp   = LPresult;
        wr_e.gp   = GPresult;
        wr_e.pred = PredictedBranch;
    end

    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            mem[tail[AW-1:0]] <= wr_e;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (resolve_valid && (count == '0)) begin
                underflow_err <= 1'b1;
            end
            // A mispredict flushes everything younger, including a same-edge alloc.
            if (retire_mis) begin
                head  <= head + 1'b1;
                tail  <= head + 1'b1;
                count <= '0;
            end else begin
                if (alloc_fire) begin
                    tail <= tail + 1'b1;
                end
                if (retire_fire) begin
                    head <= head + 1'b1;
                end
                case ({alloc_fire, retire_fire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            upd_valid  <= 1'b0;
            upd_taken  <= 1'b0;
            lp_correct <= 1'b0;
            gp_correct <= 1'b0;
            cp_train   <= 1'b0;
            cp_dir     <= 1'b0;
            mispredict <= 1'b0;
            upd_PC     <= '0;
            upd_PH     <= '0;
            recover_PH <= '0;
        end else begin
            upd_valid <= retire_fire;
            if (retire_fire) begin
                upd_taken  <= BranchTaken;
                lp_correct <= (head_e.lp == BranchTaken);
                gp_correct <= (head_e.gp == BranchTaken);
                cp_train   <= (head_e.lp != head_e.gp);
                cp_dir     <= (head_e.gp == BranchTaken);
                mispredict <= (head_e.pred != BranchTaken);
                upd_PC     <= head_e.pc;
                upd_PH     <= head_e.ph;
                recover_PH <= {head_e.ph[PH_W-2:0], BranchTaken};
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: fixed vectors, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_branch_update_queue;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [9:0]  PC = '0;
    logic [11:0] PHresult = '0;
    logic        LPresult = 1'b0;
    logic        GPresult = 1'b0;
    logic        PredictedBranch = 1'b0;
    logic        resolve_valid = 1'b0;
    logic        BranchTaken = 1'b0;
    logic        upd_valid, upd_taken, lp_correct, gp_correct, cp_train, cp_dir, mispredict;
    logic [9:0]  upd_PC;
    logic [11:0] upd_PH, recover_PH;
    logic [3:0]  count;
    logic        underflow_err;

    branch_update_queue #(.DEPTH(DEPTH), .PC_W(10), .PH_W(12)) dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .PC(PC), .PHresult(PHresult), .LPresult(LPresult), .GPresult(GPresult),
        .PredictedBranch(PredictedBranch),
        .resolve_valid(resolve_valid), .BranchTaken(BranchTaken),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .lp_correct(lp_correct),
        .gp_correct(gp_correct), .cp_train(cp_train), .cp_dir(cp_dir),
        .mispredict(mispredict), .upd_PC(upd_PC), .upd_PH(upd_PH),
        .recover_PH(recover_PH), .count(count), .underflow_err(underflow_err)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order list of outstanding predictions.
    typedef struct packed {
        logic [9:0]  pc;
        logic [11:0] ph;
        logic        lp, gp, pred;
    } ment_t;

    ment_t       mq[$];
    logic        m_vld, m_taken, m_lpc, m_gpc, m_cpt, m_cpd, m_mis, m_uf;
    logic [9:0]  m_pc;
    logic [11:0] m_ph, m_rph;

    task automatic model_reset();
        mq.delete();
        m_vld = 0; m_taken = 0; m_lpc = 0; m_gpc = 0; m_cpt = 0; m_cpd = 0;
        m_mis = 0; m_uf = 0; m_pc = '0; m_ph = '0; m_rph = '0;
    endtask

    task automatic drive(input logic a, input logic [9:0] pc, input logic [11:0] ph,
                         input logic lp, input logic gp, input logic pd,
                         input logic r, input logic t);
        alloc_valid = a; PC = pc; PHresult = ph; LPresult = lp; GPresult = gp;
        PredictedBranch = pd; resolve_valid = r; BranchTaken = t;
    endtask

    // One clock of stimulus applied to both the model and the DUT, then compared.
    task automatic cycle(input logic a, input logic [9:0] pc, input logic [11:0] ph,
                         input logic lp, input logic gp, input logic pd,
                         input logic r, input logic t);
        ment_t e;
        bit    room;
        bit    flushed;
        room    = mq.size() < DEPTH;
        flushed = 0;
        m_vld   = 0;
        if (r && mq.size() == 0) m_uf = 1;
        if (r && mq.size() > 0) begin
            e       = mq.pop_front();
            m_vld   = 1;
            m_taken = t;
            m_pc    = e.pc;
            m_ph    = e.ph;
            m_lpc   = (e.lp == t);
            m_gpc   = (e.gp == t);
            m_cpt   = (e.lp != e.gp);
            m_cpd   = (e.gp == t);
            m_mis   = (e.pred != t);
            m_rph   = {e.ph[10:0], t};
            if (m_mis) begin
                mq.delete();
                flushed = 1;
            end
        end
        if (a && room && !flushed) mq.push_back('{pc: pc, ph: ph, lp: lp, gp: gp, pred: pd});
        drive(a, pc, ph, lp, gp, pd, r, t);
        @(posedge clock);
        #1;
        check("upd_valid", upd_valid, m_vld);
        check("count", count, mq.size());
        check("alloc_ready", alloc_ready, mq.size() < DEPTH);
        check("underflow_err", underflow_err, m_uf);
        if (m_vld) begin
            check("upd_PC", upd_PC, m_pc);
            check("upd_PH", upd_PH, m_ph);
            check("upd_taken", upd_taken, m_taken);
            check("lp_correct", lp_correct, m_lpc);
            check("gp_correct", gp_correct, m_gpc);
            check("cp_train", cp_train, m_cpt);
            check("cp_dir", cp_dir, m_cpd);
            check("mispredict", mispredict, m_mis);
            check("recover_PH", recover_PH, m_rph);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, '0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        a;
        logic [9:0]  pc;
        logic [11:0] ph;
        logic        lp, gp, pd, r, t;
        logic        ev;
        logic [9:0]  epc;
        logic        emis, ecpt, ecpd, elpc, egpc;
        logic [11:0] erph;
        int          ecnt;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 10'h0A4, 12'h5A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1};
        vt[1] = '{1'b0, 10'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                  1'b1, 10'h0A4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'hB4B, 0};
        vt[2] = '{1'b1, 10'h123, 12'h800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1};
        vt[3] = '{1'b1, 10'h3FF, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                  1'b1, 10'h123, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1};
        vt[4] = '{1'b0, 10'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                  1'b1, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'hFFF, 0};
        vt[5] = '{1'b0, 10'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0};

        // Reset state
        do_reset();
        check("rst_count", count, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_underflow", underflow_err, 0);
        check("rst_upd_PC", upd_PC, 0);
        check("rst_recover_PH", recover_PH, 0);

        // Fixed vectors, starting with the basic mispredicted retire
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].a, vt[i].pc, vt[i].ph, vt[i].lp, vt[i].gp, vt[i].pd, vt[i].r, vt[i].t);
            @(posedge clock);
            #1;
            check("vec_upd_valid", upd_valid, vt[i].ev);
            check("vec_count", count, vt[i].ecnt);
            if (vt[i].ev) begin
                check("vec_upd_PC", upd_PC, vt[i].epc);
                check("vec_mispredict", mispredict, vt[i].emis);
                check("vec_cp_train", cp_train, vt[i].ecpt);
                check("vec_cp_dir", cp_dir, vt[i].ecpd);
                check("vec_lp_correct", lp_correct, vt[i].elpc);
                check("vec_gp_correct", gp_correct, vt[i].egpc);
                check("vec_recover_PH", recover_PH, vt[i].erph);
            end
        end

        // Fill to capacity, drop a 9th alloc, drain in order
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1, 10'h010 + 10'(i), 12'h100 + 12'(i), 0, 1, 0, 0, 0);
        check("full_count", count, 8);
        check("full_ready", alloc_ready, 0);
        for (int i = 0; i < 8; i++) cycle(0, '0, '0, 0, 0, 0, 1, 0);
        check("drained_count", count, 0);

        // Full queue with simultaneous alloc and retire: alloc must still be refused
        for (int i = 0; i < 8; i++) cycle(1, 10'h040 + 10'(i), 12'h0F0, 1, 1, 1, 0, 0);
        cycle(1, 10'h1FF, 12'h0F0, 1, 1, 1, 1, 1);
        check("full_retire_count", count, 7);
        for (int i = 0; i < 7; i++) cycle(0, '0, '0, 0, 0, 0, 1, 1);

        // Mispredict flush with a same-edge alloc that must never retire
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 10'h200 + 10'(i), 12'h333, 0, 0, 0, 0, 0);
        cycle(1, 10'h2EE, 12'h444, 1, 1, 1, 1, 1);
        check("flush_count", count, 0);
        idle(2);
        cycle(0, '0, '0, 0, 0, 0, 1, 0);
        check("flush_no_stale", upd_valid, 0);

        // Underflow is sticky until reset
        do_reset();
        cycle(0, '0, '0, 0, 0, 0, 1, 1);
        check("uf_set", underflow_err, 1);
        idle(3);
        cycle(1, 10'h055, 12'h055, 0, 0, 0, 0, 0);
        cycle(0, '0, '0, 0, 0, 0, 1, 0);
        check("uf_held", underflow_err, 1);
        do_reset();
        check("uf_cleared", underflow_err, 0);

        // Random interleaved traffic, crossing the pointer wrap many times
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic a, r, pd, t;
            a  = ($urandom_range(0, 99) < 60);
            r  = ($urandom_range(0, 99) < 50) && (mq.size() > 0 || $urandom_range(0, 9) == 0);
            pd = $urandom_range(0, 1);
            t  = ($urandom_range(0, 99) < 90) ? pd : ~pd;
            cycle(a, 10'($urandom), 12'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 1), pd, r, t);
        end

        // Asynchronous reset mid-operation with five entries outstanding
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 10'h300 + 10'(i), 12'hABC, 1, 0, 1, 0, 0);
        cycle(0, '0, '0, 0, 0, 0, 1, 1);
        check("pre_rst_count", count, 5);
        drive(0, '0, '0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_count", count, 0);
        check("async_upd_valid", upd_valid, 0);
        check("async_upd_PC", upd_PC, 0);
        check("async_upd_PH", upd_PH, 0);
        check("async_recover_PH", recover_PH, 0);
        check("async_mispredict", mispredict, 0);
        check("async_cp_train", cp_train, 0);
        check("async_underflow", underflow_err, 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        check("post_rst_ready", alloc_ready, 1);
        @(posedge clock);
        #1;
        idle(4);
        check("post_rst_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
